// File: rtl/parking_fee_biller_pkg.sv
// Shared types and default widths for the parking session biller.
// FSM encoding and the default timer/fee widths.
package parking_fee_biller_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_CALC = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam int TIME_W_DEF = 12;
  localparam int FEE_W_DEF  = 16;

endpackage : parking_fee_biller_pkg

// File: rtl/parking_fee_biller_if.sv
// Fee delivery handshake between the biller and the gate/display logic.
// fee is held stable while fee_valid is high until fee_ready is seen.
interface parking_fee_biller_if #(
  parameter int FEE_W = 16
) ();

  logic [FEE_W-1:0] fee;
  logic             fee_valid;
  logic             fee_ready;

  modport master (
    output fee,
    output fee_valid,
    input  fee_ready
  );

  modport slave (
    input  fee,
    input  fee_valid,
    output fee_ready
  );

endinterface : parking_fee_biller_if

// File: rtl/parking_fee_biller_fee_accumulator.sv
// Iterative fee accumulator: one RATE increment per step, stopping when the
// billable count runs out or the daily cap is reached.
module parking_fee_biller_fee_accumulator #(
  parameter int TIME_W    = 12,
  parameter int FEE_W     = 16,
  parameter int RATE      = 5,
  parameter int DAILY_CAP = 60
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [TIME_W-1:0] load_cnt_i,
  input  logic              step_i,
  output logic              done_o,
  output logic [FEE_W-1:0]  fee_o
);

  localparam int ACC_W = FEE_W + 1;
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {FEE_W{1'b1}}};
  localparam logic [ACC_W-1:0] CAP_A   = ACC_W'(DAILY_CAP);

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [TIME_W-1:0] cnt_q, cnt_d;

  // Add one RATE, clamping at the largest value the fee port can carry.
  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a);
    logic [ACC_W:0] s;
    s = {1'b0, a} + (ACC_W + 1)'(RATE);
    if (s > {1'b0, ACC_MAX}) begin
      return ACC_MAX;
    end
    return s[ACC_W-1:0];
  endfunction

  function automatic logic [FEE_W-1:0] cap_fee(input logic [ACC_W-1:0] a);
    if (a >= CAP_A) begin
      return CAP_A[FEE_W-1:0];
    end
    return a[FEE_W-1:0];
  endfunction

  assign done_o = (cnt_q == '0) || (acc_q >= CAP_A);
  assign fee_o  = cap_fee(acc_q);

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (load_i) begin
      acc_d = '0;
      cnt_d = load_cnt_i;
    end else if (step_i && !done_o) begin
      acc_d = sat_add(acc_q);
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule : parking_fee_biller_fee_accumulator

// File: rtl/parking_fee_biller.sv
// Parking session controller: runs the timer for one car, captures the elapsed
// count on exit, computes the fee iteratively and hands it off on valid/ready.
module parking_fee_biller
  import parking_fee_biller_pkg::*;
#(
  parameter int TIME_W     = TIME_W_DEF,
  parameter int FEE_W      = FEE_W_DEF,
  parameter int FREE_UNITS = 1,
  parameter int RATE       = 5,
  parameter int DAILY_CAP  = 60
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 entry,
  input  logic                 exit_req,
  input  logic [TIME_W-1:0]    timer_time,
  output logic                 timer_start,
  output logic                 busy,
  output logic                 err_no_entry,
  parking_fee_biller_if.master fee_bus
);

  localparam logic [TIME_W-1:0] FREE_T = TIME_W'(FREE_UNITS);

  state_e            state_q, state_d;
  logic              timer_start_q, timer_start_d;
  logic [FEE_W-1:0]  fee_q, fee_d;
  logic              fee_valid_q, fee_valid_d;
  logic              err_q, err_d;
  logic [TIME_W-1:0] t_cap_q, t_cap_d;

  logic              acc_load, acc_step, acc_done;
  logic [TIME_W-1:0] load_cnt;
  logic [FEE_W-1:0]  acc_fee;

  // A timer that wrapped to a small value simply bills fewer (possibly zero) units.
  assign load_cnt = (timer_time > FREE_T) ? (timer_time - FREE_T) : '0;

  parking_fee_biller_fee_accumulator #(
    .TIME_W    (TIME_W),
    .FEE_W     (FEE_W),
    .RATE      (RATE),
    .DAILY_CAP (DAILY_CAP)
  ) u_acc (
    .clk        (clk),
    .rst        (rst),
    .load_i     (acc_load),
    .load_cnt_i (load_cnt),
    .step_i     (acc_step),
    .done_o     (acc_done),
    .fee_o      (acc_fee)
  );

  always_comb begin
    state_d       = state_q;
    timer_start_d = timer_start_q;
    fee_d         = fee_q;
    fee_valid_d   = fee_valid_q;
    err_d         = 1'b0;
    t_cap_d       = t_cap_q;
    acc_load      = 1'b0;
    acc_step      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (entry) begin
          timer_start_d = 1'b1;
          state_d       = S_RUN;
        end else if (exit_req) begin
          err_d = 1'b1;
        end
      end
      S_RUN: begin
        if (exit_req) begin
          t_cap_d       = timer_time;
          timer_start_d = 1'b0;
          acc_load      = 1'b1;
          state_d       = S_CALC;
        end
      end
      S_CALC: begin
        if (acc_done) begin
          fee_d       = acc_fee;
          fee_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          acc_step = 1'b1;
        end
      end
      S_DONE: begin
        if (fee_valid_q && fee_bus.fee_ready) begin
          fee_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      timer_start_q <= 1'b0;
      fee_q         <= '0;
      fee_valid_q   <= 1'b0;
      err_q         <= 1'b0;
      t_cap_q       <= '0;
    end else begin
      state_q       <= state_d;
      timer_start_q <= timer_start_d;
      fee_q         <= fee_d;
      fee_valid_q   <= fee_valid_d;
      err_q         <= err_d;
      t_cap_q       <= t_cap_d;
    end
  end

  assign timer_start       = timer_start_q;
  assign busy              = (state_q != S_IDLE);
  assign err_no_entry      = err_q;
  assign fee_bus.fee       = fee_q;
  assign fee_bus.fee_valid = fee_valid_q;

endmodule : parking_fee_biller

// File: tb/tb_parking_fee_biller.sv
// Bench for parking_fee_biller: fixed vectors, corner-case sequences and
// randomized sessions against a fee/latency reference model.
module tb_parking_fee_biller;

  localparam int TIME_W     = 12;
  localparam int FEE_W      = 16;
  localparam int FREE_UNITS = 1;
  localparam int RATE       = 5;
  localparam int DAILY_CAP  = 60;
  localparam int BOUND      = 200;

  logic              clk = 1'b0;
  logic              rst;
  logic              entry;
  logic              exit_req;
  logic [TIME_W-1:0] timer_time;
  logic              timer_start;
  logic              busy;
  logic              err_no_entry;

  parking_fee_biller_if #(.FEE_W(FEE_W)) fbus ();

  parking_fee_biller #(
    .TIME_W     (TIME_W),
    .FEE_W      (FEE_W),
    .FREE_UNITS (FREE_UNITS),
    .RATE       (RATE),
    .DAILY_CAP  (DAILY_CAP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .entry        (entry),
    .exit_req     (exit_req),
    .timer_time   (timer_time),
    .timer_start  (timer_start),
    .busy         (busy),
    .err_no_entry (err_no_entry),
    .fee_bus      (fbus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int t;
    int hold;
    int fee;
    int lat;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fee is the billable units times RATE, capped; the session stops
  // stepping once the units are used up or the cap is reached.
  function automatic void ref_fee(input int t, output int f, output int lat);
    int b;
    int steps_to_cap;
    b            = (t > FREE_UNITS) ? t - FREE_UNITS : 0;
    steps_to_cap = (DAILY_CAP + RATE - 1) / RATE;
    f            = (b * RATE < DAILY_CAP) ? b * RATE : DAILY_CAP;
    lat          = ((b < steps_to_cap) ? b : steps_to_cap) + 1;
  endfunction

  task automatic chk_idle_outputs(input string nm, input int exp_fee);
    chk({nm, ".timer_start"}, 32'(timer_start), 0);
    chk({nm, ".busy"}, 32'(busy), 0);
    chk({nm, ".fee_valid"}, 32'(fbus.fee_valid), 0);
    chk({nm, ".err"}, 32'(err_no_entry), 0);
    chk({nm, ".fee"}, 32'(fbus.fee), 32'(exp_fee));
  endtask

  task automatic session(input string nm, input int t, input int hold,
                         input int exp_f, input int exp_l, input bit with_exit);
    int k;
    entry    = 1'b1;
    exit_req = with_exit;
    tick();
    entry    = 1'b0;
    exit_req = 1'b0;
    chk({nm, ".start_on"}, 32'(timer_start), 1);
    chk({nm, ".busy_run"}, 32'(busy), 1);
    chk({nm, ".no_err"}, 32'(err_no_entry), 0);
    entry = 1'b1;
    tick();
    entry = 1'b0;
    chk({nm, ".start_held"}, 32'(timer_start), 1);
    timer_time = TIME_W'(t);
    exit_req   = 1'b1;
    tick();
    exit_req   = 1'b0;
    timer_time = '0;
    chk({nm, ".start_off"}, 32'(timer_start), 0);
    k = 0;
    while (fbus.fee_valid !== 1'b1 && k < BOUND) begin
      exit_req = 1'b1;
      tick();
      exit_req = 1'b0;
      k++;
    end
    chk({nm, ".latency"}, 32'(k), 32'(exp_l));
    chk({nm, ".fee"}, 32'(fbus.fee), 32'(exp_f));
    chk({nm, ".err_vs_valid"}, 32'(err_no_entry), 0);
    fbus.fee_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({nm, ".hold_fee"}, 32'(fbus.fee), 32'(exp_f));
      chk({nm, ".hold_valid"}, 32'(fbus.fee_valid), 1);
    end
    fbus.fee_ready = 1'b1;
    tick();
    fbus.fee_ready = 1'b0;
    chk_idle_outputs({nm, ".after"}, exp_f);
  endtask

  initial begin
    int f;
    int l;
    int t;
    rst            = 1'b1;
    entry          = 1'b0;
    exit_req       = 1'b0;
    timer_time     = '0;
    fbus.fee_ready = 1'b0;

    tbl[0] = '{t: 5,    hold: 0, fee: 20, lat: 5};
    tbl[1] = '{t: 20,   hold: 1, fee: 60, lat: 13};
    tbl[2] = '{t: 0,    hold: 0, fee: 0,  lat: 1};
    tbl[3] = '{t: 1,    hold: 2, fee: 0,  lat: 1};
    tbl[4] = '{t: 2,    hold: 3, fee: 5,  lat: 2};
    tbl[5] = '{t: 12,   hold: 0, fee: 55, lat: 12};
    tbl[6] = '{t: 13,   hold: 1, fee: 60, lat: 13};
    tbl[7] = '{t: 14,   hold: 0, fee: 60, lat: 13};
    tbl[8] = '{t: 4095, hold: 3, fee: 60, lat: 13};
    tbl[9] = '{t: 3,    hold: 0, fee: 10, lat: 3};

    tick();
    tick();
    rst = 1'b0;
    chk_idle_outputs("reset", 0);

    for (int i = 0; i < 10; i++) begin
      session($sformatf("vec%0d", i), tbl[i].t, tbl[i].hold, tbl[i].fee, tbl[i].lat, 1'b0);
    end

    exit_req = 1'b1;
    tick();
    exit_req = 1'b0;
    chk("err_pulse", 32'(err_no_entry), 1);
    chk("err_busy", 32'(busy), 0);
    tick();
    chk("err_clear", 32'(err_no_entry), 0);

    session("both_in_idle", 4, 0, 15, 4, 1'b1);

    entry = 1'b1;
    tick();
    entry = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle_outputs("rst_run", 0);

    session("post_rst_run", 6, 1, 25, 6, 1'b0);

    entry = 1'b1;
    tick();
    entry      = 1'b0;
    timer_time = TIME_W'(20);
    exit_req   = 1'b1;
    tick();
    exit_req   = 1'b0;
    timer_time = '0;
    tick();
    tick();
    chk("calc_busy", 32'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle_outputs("rst_calc", 0);

    session("post_rst_calc", 7, 0, 30, 7, 1'b0);

    for (int i = 0; i < 30; i++) begin
      t = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4095))
                                      : int'($urandom_range(0, 20));
      ref_fee(t, f, l);
      session($sformatf("rnd%0d_t%0d", i, t), t, int'($urandom_range(0, 3)), f, l, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_parking_fee_biller
